// File: rtl/uart_tx_parity_pkg.sv
// uart_tx_parity_pkg: shared UART frame states, timing constants and parity helper
package uart_tx_parity_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;
  localparam int BIT_TICKS = 16;
  localparam int SB_ONE = 16;
  localparam int SB_ONE_HALF = 24;
  localparam int SB_TWO = 32;
  function automatic logic calc_parity(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
  function automatic logic sb_tick_legal(input int sb);
    return (sb == SB_ONE) || (sb == SB_ONE_HALF) || (sb == SB_TWO);
  endfunction
endpackage

// File: rtl/uart_tx_parity.sv
// uart_tx_parity: 16x-tick UART transmitter with optional parity and configurable stop length
module uart_tx_parity
  import uart_tx_parity_pkg::*;
#(
  parameter int DBIT = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY_EN = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_valid,
  input  logic [DBIT-1:0] din,
  output logic            tx_ready,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);
  localparam int TW = ($clog2(SB_TICK) < 4) ? 4 : $clog2(SB_TICK);
  localparam int BW = $clog2(DBIT) + 1;
  localparam logic SB_OK = sb_tick_legal(SB_TICK);
  state_t r_state, w_state_next;
  logic [TW-1:0] r_tick_cnt, w_tick_cnt_next;
  logic [BW-1:0] r_bit_cnt, w_bit_cnt_next;
  logic [DBIT-1:0] r_shift, w_shift_next;
  logic r_parity, w_parity_next;
  logic r_tx, w_tx_next;
  logic r_done, w_done_next;
  logic w_bit_end, w_stop_end;
  // Illegal stop lengths fall back to one stop bit rather than an odd-length stop.
  assign w_bit_end = s_tick && (r_tick_cnt == TW'(BIT_TICKS - 1));
  assign w_stop_end = s_tick && (r_tick_cnt == (SB_OK ? TW'(SB_TICK - 1) : TW'(SB_ONE - 1)));
  assign tx_ready = (r_state == ST_IDLE);
  assign tx_busy = ~tx_ready;
  assign tx_done_tick = r_done;
  assign tx = r_tx;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= ST_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift <= '0;
      r_parity <= 1'b0;
      r_tx <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tick_cnt <= w_tick_cnt_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_shift <= w_shift_next;
      r_parity <= w_parity_next;
      r_tx <= w_tx_next;
      r_done <= w_done_next;
    end
  always_comb begin
    w_state_next = r_state;
    w_tick_cnt_next = r_tick_cnt;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next = r_shift;
    w_parity_next = r_parity;
    w_done_next = 1'b0;
    case (r_state)
      ST_IDLE:
        if (tx_valid) begin
          w_state_next = ST_START;
          w_shift_next = din;
          w_parity_next = calc_parity(8'(din), PARITY_ODD != 0);
          w_tick_cnt_next = '0;
          w_bit_cnt_next = '0;
        end
      ST_START, ST_PARITY:
        if (s_tick) begin
          w_tick_cnt_next = w_bit_end ? '0 : r_tick_cnt + 1'b1;
          w_state_next = !w_bit_end ? r_state : (r_state == ST_START) ? ST_DATA : ST_STOP;
        end
      ST_DATA:
        if (s_tick) begin
          w_tick_cnt_next = w_bit_end ? '0 : r_tick_cnt + 1'b1;
          if (w_bit_end) begin
            w_shift_next = r_shift >> 1;
            w_bit_cnt_next = (r_bit_cnt == BW'(DBIT - 1)) ? r_bit_cnt : r_bit_cnt + 1'b1;
            w_state_next = (r_bit_cnt != BW'(DBIT - 1)) ? ST_DATA : (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end
        end
      ST_STOP:
        if (s_tick) begin
          w_tick_cnt_next = w_stop_end ? '0 : r_tick_cnt + 1'b1;
          w_state_next = w_stop_end ? ST_IDLE : ST_STOP;
          w_done_next = w_stop_end;
        end
      default: w_state_next = ST_IDLE;
    endcase
    w_tx_next = (w_state_next == ST_START) ? 1'b0 :
                (w_state_next == ST_DATA) ? w_shift_next[0] :
                (w_state_next == ST_PARITY) ? w_parity_next : 1'b1;
  end
endmodule
